// File: rtl/aha_tlx_pkg.sv
// ---------------------------------------------------------------------------
// aha_tlx_pkg
// Shared constants and types for the TLX AXI4 scratchpad slave.
//   BURST_*  : AXI burst-type encodings
//   RESP_*   : AXI response encodings
//   tlx_state_e : slave FSM states
// ---------------------------------------------------------------------------
package aha_tlx_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_WRESP = 2'd2,
      ST_RDATA = 2'd3
   } tlx_state_e;

endpackage

// File: rtl/aha_tlx_scratch_mem.sv
// ---------------------------------------------------------------------------
// aha_tlx_scratch_mem
// DEPTH x DATA_W flop array with a byte-enable write port and a
// combinational read port. Contents are never reset.
// Ports:
//   clk      in  clock
//   wr_en    in  write enable for this cycle
//   wr_idx   in  word index to write
//   wr_strb  in  per-byte write enables
//   wr_data  in  write data
//   rd_idx   in  word index to read
//   rd_data  out combinational read data
// ---------------------------------------------------------------------------
module aha_tlx_scratch_mem #(
   parameter int  DATA_W = 64,
   parameter int  DEPTH  = 256,
   localparam int BYTES  = DATA_W / 8,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [BYTES-1:0]  wr_strb,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_array [DEPTH];
   logic [DATA_W-1:0] wr_mask;

   // Expand byte strobes into a bit mask so the write is a single merge.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
         assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_array[wr_idx] <= (mem_array[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   assign rd_data = mem_array[rd_idx];

endmodule

// File: rtl/aha_tlx_axi_scratchpad.sv
// ---------------------------------------------------------------------------
// aha_tlx_axi_scratchpad
// AXI4 slave on the TLX port backed by a byte-writable scratchpad.
// One transaction in flight; INCR/FIXED bursts (WRAP/reserved act as INCR);
// SLVERR on beats outside [BASE_ADDR, BASE_ADDR + DEPTH*BYTES); AW/AR ties
// alternate, the first tie after reset going to the write.
// Ports:
//   TLX_CLK, TLX_RESET (async, active-high)
//   TLX_AW{ID,ADDR,LEN,BURST,VALID,READY}  write address channel
//   TLX_W{DATA,STRB,LAST,VALID,READY}      write data channel
//   TLX_B{ID,RESP,VALID,READY}             write response channel
//   TLX_AR{ID,ADDR,LEN,BURST,VALID,READY}  read address channel
//   TLX_R{ID,DATA,RESP,LAST,VALID,READY}   read data channel
// Optional build macro AHA_TLX_SCRATCH_STATS_EN adds TLX_WR_BEATS and
// TLX_RD_BEATS: saturating counts of accepted W and R handshakes.
// ---------------------------------------------------------------------------
module aha_tlx_axi_scratchpad
   import aha_tlx_pkg::*;
#(
   parameter int          DATA_W    = 64,
   parameter int          ID_W      = 4,
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   localparam int         BYTES     = DATA_W / 8
) (
   input  logic              TLX_CLK,
   input  logic              TLX_RESET,
   input  logic [ID_W-1:0]   TLX_AWID,
   input  logic [31:0]       TLX_AWADDR,
   input  logic [7:0]        TLX_AWLEN,
   input  logic [1:0]        TLX_AWBURST,
   input  logic              TLX_AWVALID,
   output logic              TLX_AWREADY,
   input  logic [DATA_W-1:0] TLX_WDATA,
   input  logic [BYTES-1:0]  TLX_WSTRB,
   input  logic              TLX_WLAST,
   input  logic              TLX_WVALID,
   output logic              TLX_WREADY,
   output logic [ID_W-1:0]   TLX_BID,
   output logic [1:0]        TLX_BRESP,
   output logic              TLX_BVALID,
   input  logic              TLX_BREADY,
   input  logic [ID_W-1:0]   TLX_ARID,
   input  logic [31:0]       TLX_ARADDR,
   input  logic [7:0]        TLX_ARLEN,
   input  logic [1:0]        TLX_ARBURST,
   input  logic              TLX_ARVALID,
   output logic              TLX_ARREADY,
   output logic [ID_W-1:0]   TLX_RID,
   output logic [DATA_W-1:0] TLX_RDATA,
   output logic [1:0]        TLX_RRESP,
   output logic              TLX_RLAST,
   output logic              TLX_RVALID,
   input  logic              TLX_RREADY
`ifdef AHA_TLX_SCRATCH_STATS_EN
   ,
   output logic [31:0]       TLX_WR_BEATS,
   output logic [31:0]       TLX_RD_BEATS
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OFF_W = $clog2(BYTES);

   // 33-bit window bounds so a window touching 4 GiB does not wrap.
   localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] WIN_HI = WIN_LO + 33'(DEPTH * BYTES);

   function automatic logic in_window(input logic [31:0] a);
      return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> OFF_W);
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
      return (b == BURST_FIXED) ? a : a + 32'(BYTES);
   endfunction

   tlx_state_e        state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [31:0]       addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [1:0]        burst_q, burst_d;
   logic [7:0]        beat_q, beat_d;
   logic              err_q, err_d;
   logic              last_rd_q, last_rd_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rlast_q, rlast_d;

   logic              aw_ready;
   logic              ar_ready;
   logic              mem_we;
   logic [31:0]       rd_addr;
   logic [DATA_W-1:0] mem_rd_data;

   // Ties alternate: last_rd high means the previous grant was a read.
   assign aw_ready = (state_q == ST_IDLE) & TLX_AWVALID & (~TLX_ARVALID | last_rd_q) & ~TLX_RESET;
   assign ar_ready = (state_q == ST_IDLE) & TLX_ARVALID & ~aw_ready & ~TLX_RESET;

   // In IDLE the read port looks at the incoming AR address (beat 0);
   // otherwise it looks one beat ahead so R can stream without bubbles.
   assign rd_addr = (state_q == ST_IDLE) ? TLX_ARADDR : next_addr(addr_q, burst_q);

   aha_tlx_scratch_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (TLX_CLK),
      .wr_en   (mem_we),
      .wr_idx  (word_idx(addr_q)),
      .wr_strb (TLX_WSTRB),
      .wr_data (TLX_WDATA),
      .rd_idx  (word_idx(rd_addr)),
      .rd_data (mem_rd_data)
   );

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      err_d     = err_q;
      last_rd_d = last_rd_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      mem_we    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (aw_ready) begin
               id_d      = TLX_AWID;
               addr_d    = TLX_AWADDR;
               len_d     = TLX_AWLEN;
               burst_d   = TLX_AWBURST;
               beat_d    = 8'd0;
               err_d     = 1'b0;
               last_rd_d = 1'b0;
               state_d   = ST_WDATA;
            end else if (ar_ready) begin
               id_d      = TLX_ARID;
               addr_d    = TLX_ARADDR;
               len_d     = TLX_ARLEN;
               burst_d   = TLX_ARBURST;
               beat_d    = 8'd0;
               last_rd_d = 1'b1;
               rvalid_d  = 1'b1;
               rdata_d   = in_window(TLX_ARADDR) ? mem_rd_data : '0;
               rresp_d   = in_window(TLX_ARADDR) ? RESP_OKAY : RESP_SLVERR;
               rlast_d   = (TLX_ARLEN == 8'd0);
               state_d   = ST_RDATA;
            end
         end

         ST_WDATA: begin
            if (TLX_WVALID) begin
               mem_we = in_window(addr_q);
               // Burst length comes from LEN; WLAST only flags a mismatch.
               if (!in_window(addr_q) || (TLX_WLAST != (beat_q == len_q))) begin
                  err_d = 1'b1;
               end
               if (beat_q == len_q) begin
                  state_d = ST_WRESP;
               end else begin
                  beat_d = beat_q + 8'd1;
                  addr_d = next_addr(addr_q, burst_q);
               end
            end
         end

         ST_WRESP: begin
            if (TLX_BREADY) begin
               state_d = ST_IDLE;
            end
         end

         ST_RDATA: begin
            if (TLX_RREADY) begin
               if (rlast_q) begin
                  rvalid_d = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  addr_d  = rd_addr;
                  rdata_d = in_window(rd_addr) ? mem_rd_data : '0;
                  rresp_d = in_window(rd_addr) ? RESP_OKAY : RESP_SLVERR;
                  rlast_d = ((beat_q + 8'd1) == len_q);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge TLX_CLK or posedge TLX_RESET) begin
      if (TLX_RESET) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         last_rd_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         last_rd_q <= last_rd_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   assign TLX_AWREADY = aw_ready;
   assign TLX_ARREADY = ar_ready;
   assign TLX_WREADY  = (state_q == ST_WDATA);
   assign TLX_BVALID  = (state_q == ST_WRESP);
   assign TLX_BID     = id_q;
   assign TLX_BRESP   = err_q ? RESP_SLVERR : RESP_OKAY;
   assign TLX_RVALID  = rvalid_q;
   assign TLX_RID     = id_q;
   assign TLX_RDATA   = rdata_q;
   assign TLX_RRESP   = rresp_q;
   assign TLX_RLAST   = rlast_q;

`ifdef AHA_TLX_SCRATCH_STATS_EN
   logic [31:0] wr_beats_q, wr_beats_d;
   logic [31:0] rd_beats_q, rd_beats_d;

   always_comb begin
      wr_beats_d = wr_beats_q;
      rd_beats_d = rd_beats_q;
      if ((state_q == ST_WDATA) && TLX_WVALID && (wr_beats_q != 32'hFFFF_FFFF)) begin
         wr_beats_d = wr_beats_q + 32'd1;
      end
      if (rvalid_q && TLX_RREADY && (rd_beats_q != 32'hFFFF_FFFF)) begin
         rd_beats_d = rd_beats_q + 32'd1;
      end
   end

   always_ff @(posedge TLX_CLK or posedge TLX_RESET) begin
      if (TLX_RESET) begin
         wr_beats_q <= '0;
         rd_beats_q <= '0;
      end else begin
         wr_beats_q <= wr_beats_d;
         rd_beats_q <= rd_beats_d;
      end
   end

   assign TLX_WR_BEATS = wr_beats_q;
   assign TLX_RD_BEATS = rd_beats_q;
`else
   // Beat counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_aha_tlx_axi_scratchpad.sv
// ---------------------------------------------------------------------------
// tb_aha_tlx_axi_scratchpad
// Directed bench for aha_tlx_axi_scratchpad (DATA_W=64, DEPTH=256, BASE=0).
// ---------------------------------------------------------------------------
module tb_aha_tlx_axi_scratchpad;

   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
`ifdef AHA_TLX_SCRATCH_STATS_EN
   logic [31:0] wr_beats;
   logic [31:0] rd_beats;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   aha_tlx_axi_scratchpad #(
      .DATA_W    (64),
      .ID_W      (4),
      .DEPTH     (256),
      .BASE_ADDR (32'h0)
   ) dut (
      .TLX_CLK     (clk),
      .TLX_RESET   (rst),
      .TLX_AWID    (awid),
      .TLX_AWADDR  (awaddr),
      .TLX_AWLEN   (awlen),
      .TLX_AWBURST (awburst),
      .TLX_AWVALID (awvalid),
      .TLX_AWREADY (awready),
      .TLX_WDATA   (wdata),
      .TLX_WSTRB   (wstrb),
      .TLX_WLAST   (wlast),
      .TLX_WVALID  (wvalid),
      .TLX_WREADY  (wready),
      .TLX_BID     (bid),
      .TLX_BRESP   (bresp),
      .TLX_BVALID  (bvalid),
      .TLX_BREADY  (bready),
      .TLX_ARID    (arid),
      .TLX_ARADDR  (araddr),
      .TLX_ARLEN   (arlen),
      .TLX_ARBURST (arburst),
      .TLX_ARVALID (arvalid),
      .TLX_ARREADY (arready),
      .TLX_RID     (rid),
      .TLX_RDATA   (rdata),
      .TLX_RRESP   (rresp),
      .TLX_RLAST   (rlast),
      .TLX_RVALID  (rvalid),
      .TLX_RREADY  (rready)
`ifdef AHA_TLX_SCRATCH_STATS_EN
      ,
      .TLX_WR_BEATS (wr_beats),
      .TLX_RD_BEATS (rd_beats)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end at posedge+1.
   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
      @(negedge clk);
      while (!awready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("aw_ready", 128'(awready), 128'(1'b1));
      @(posedge clk); #1;
      awvalid = 1'b0;
      $display("AW id=%0h addr=%08h len=%0d burst=%0d", id, addr, len, burst);
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
      @(negedge clk);
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ar_ready", 128'(arready), 128'(1'b1));
      @(posedge clk); #1;
      arvalid = 1'b0;
      $display("AR id=%0h addr=%08h len=%0d burst=%0d", id, addr, len, burst);
   endtask

   task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
      @(negedge clk);
      while (!wready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("w_ready", 128'(wready), 128'(1'b1));
      @(posedge clk); #1;
      wvalid = 1'b0;
      $display("W  data=%016h strb=%02h last=%0d", data, strb, last);
   endtask

   task automatic do_b(input logic [3:0] exp_id, input logic [1:0] exp_resp, output int waited);
      int n = 0;
      bready = 1'b1;
      @(negedge clk);
      while (!bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      chk("b_valid", 128'(bvalid), 128'(1'b1));
      chk("b_id_resp", 128'({bid, bresp}), 128'({exp_id, exp_resp}));
      $display("B  id=%0h resp=%0d (expect id=%0h resp=%0d)", bid, bresp, exp_id, exp_resp);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   // Leaves RREADY high so consecutive calls stream back-to-back beats.
   task automatic do_r(input string tag, input logic [63:0] exp_data, input logic [1:0] exp_resp,
                       input logic exp_last, input logic [3:0] exp_id, output int waited);
      int n = 0;
      rready = 1'b1;
      @(negedge clk);
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      chk({tag, "_valid"}, 128'(rvalid), 128'(1'b1));
      chk(tag, 128'({rid, rresp, rlast, rdata}), 128'({exp_id, exp_resp, exp_last, exp_data}));
      $display("R  %s id=%0h data=%016h resp=%0d last=%0d", tag, rid, rdata, rresp, rlast);
      @(posedge clk); #1;
   endtask

   // Hold RREADY low for two cycles and require the presented beat to stay put.
   task automatic stall_chk(input string tag, input logic [63:0] exp_data,
                            input logic exp_last, input logic [3:0] exp_id);
      rready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk(tag, 128'({rvalid, rid, rresp, rlast, rdata}),
             128'({1'b1, exp_id, OKAY, exp_last, exp_data}));
         $display("R  %s stalled data=%016h last=%0d", tag, rdata, rlast);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst = 1'b1;
      awid = 4'h2; awaddr = 32'h100; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arburst = INCR; arvalid = 1'b0; rready = 1'b0;

      // 1. Reset with AWVALID held high.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          128'({awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rresp, rlast, rdata}),
          128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("awready_after_reset", 128'(awready), 128'(1'b1));
      @(posedge clk); #1;
      awvalid = 1'b0;
      do_w(64'h0, 8'h00, 1'b1);
      do_b(4'h2, OKAY, w);

      // 2. INCR write then readback, checking latency and bubble-free R.
      do_aw(4'h5, 32'h10, 8'd3, INCR);
      for (int k = 1; k <= 4; k++) do_w(64'(k), 8'hFF, k == 4);
      do_b(4'h5, OKAY, w);
      chk("b_latency", 128'(w), 128'(0));
      do_ar(4'h9, 32'h10, 8'd3, INCR);
      for (int k = 1; k <= 4; k++) begin
         do_r("incr_rd", 64'(k), OKAY, k == 4, 4'h9, w);
         chk("r_no_bubble", 128'(w), 128'(0));
      end
      rready = 1'b0;

      // 3. Byte strobes.
      do_aw(4'h1, 32'h40, 8'd0, INCR);
      do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
      do_b(4'h1, OKAY, w);
      do_aw(4'h1, 32'h40, 8'd0, INCR);
      do_w(64'h0, 8'h0F, 1'b1);
      do_b(4'h1, OKAY, w);
      do_ar(4'h1, 32'h40, 8'd0, INCR);
      do_r("strb_rd", 64'hFFFF_FFFF_0000_0000, OKAY, 1'b1, 4'h1, w);
      rready = 1'b0;

      // 4. Burst crossing the top of the window.
      do_aw(4'h3, 32'h7F8, 8'd1, INCR);
      do_w(64'hDEAD_BEEF_0000_07F8, 8'hFF, 1'b0);
      do_w(64'h1234, 8'hFF, 1'b1);
      do_b(4'h3, SLVERR, w);
      do_ar(4'h4, 32'h7F8, 8'd1, INCR);
      do_r("edge_rd0", 64'hDEAD_BEEF_0000_07F8, OKAY, 1'b0, 4'h4, w);
      do_r("edge_rd1", 64'h0, SLVERR, 1'b1, 4'h4, w);
      rready = 1'b0;

      // 5. Simultaneous AW/AR: grants alternate starting with write.
      for (int i = 0; i < 4; i++) begin
         logic exp_w;
         exp_w = (i % 2 == 0);
         awid = 4'h6; awaddr = 32'h300 + 32'(i * 8); awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
         arid = 4'h7; araddr = 32'h10; arlen = 8'd0; arburst = INCR; arvalid = 1'b1;
         @(negedge clk);
         chk("grant", 128'({awready, arready}), 128'({exp_w, ~exp_w}));
         $display("ARB round=%0d awready=%0d arready=%0d", i, awready, arready);
         @(posedge clk); #1;
         awvalid = 1'b0;
         arvalid = 1'b0;
         if (exp_w) begin
            do_w(64'hA5A5_0000 + 64'(i), 8'hFF, 1'b1);
            do_b(4'h6, OKAY, w);
         end else begin
            do_r("arb_rd", 64'h1, OKAY, 1'b1, 4'h7, w);
            rready = 1'b0;
         end
      end

      // FIXED read with stalls.
      do_ar(4'h8, 32'h10, 8'd2, FIXED);
      stall_chk("fixed_stall0", 64'h1, 1'b0, 4'h8);
      do_r("fixed_rd0", 64'h1, OKAY, 1'b0, 4'h8, w);
      stall_chk("fixed_stall1", 64'h1, 1'b0, 4'h8);
      do_r("fixed_rd1", 64'h1, OKAY, 1'b0, 4'h8, w);
      stall_chk("fixed_stall2", 64'h1, 1'b1, 4'h8);
      do_r("fixed_rd2", 64'h1, OKAY, 1'b1, 4'h8, w);
      rready = 1'b0;
      @(negedge clk);
      chk("rvalid_drop", 128'(rvalid), 128'(1'b0));
      @(posedge clk); #1;

      // 6. Reset in the middle of a LEN=7 write.
      do_aw(4'hA, 32'h200, 8'd7, INCR);
      for (int k = 0; k < 8; k++) do_w(64'hA0 + 64'(k), 8'hFF, k == 7);
      do_b(4'hA, OKAY, w);
      do_aw(4'hB, 32'h200, 8'd7, INCR);
      do_w(64'hB0, 8'hFF, 1'b0);
      do_w(64'hB1, 8'hFF, 1'b0);
      wdata = 64'hB2; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("reset_mid_burst",
          128'({awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rresp, rlast, rdata}),
          128'(0));
      $display("RST asserted mid-burst wready=%0d bvalid=%0d", wready, bvalid);
      @(posedge clk); #1;
      wvalid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      do_ar(4'hC, 32'h200, 8'd7, INCR);
      do_r("post_rst0", 64'hB0, OKAY, 1'b0, 4'hC, w);
      do_r("post_rst1", 64'hB1, OKAY, 1'b0, 4'hC, w);
      for (int k = 2; k < 8; k++) do_r("post_rst_old", 64'hA0 + 64'(k), OKAY, k == 7, 4'hC, w);
      rready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
